if_ctrl: RTL

Instruction-fetch controller that drives `pc_back` into `pc_reg` and fills it with instructions. Fetches each 32-bit instruction as four byte reads over the shared 8-bit memory port and assembles them little-endian. Hands each instruction to ID with a valid/ready handshake. Applies branch redirects from EX and honours pipeline stalls.

---
 rtl/if_ctrl_pkg.sv | 14 +
 rtl/if_ctrl.sv | 92 +++++++++
 2 files changed

// File: rtl/if_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: reset polarity,
// bus widths and the fetch state encoding.
package if_ctrl_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam int   InstAddrBus = 32;
  localparam int   InstBus     = 32;

  typedef enum logic {
    IfFetch = 1'b0,
    IfHold  = 1'b1
  } if_state_e;

endpackage

// File: rtl/if_ctrl.sv
// Instruction fetch: four byte reads per word over an 8-bit port, assembled
// little-endian, handed to ID with valid/ready; branch redirects and stalls.
module if_ctrl
  import if_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_in,
  input  logic                   br_flag,
  input  logic [InstAddrBus-1:0] br_target,
  output logic                   mem_req,
  output logic [InstAddrBus-1:0] mem_addr,
  input  logic                   mem_gnt,
  input  logic [7:0]             mem_rdata,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [InstBus-1:0]     inst,
  output logic [InstAddrBus-1:0] inst_pc,
  output logic [InstAddrBus-1:0] pc_back
);

  if_state_e              state, state_nxt;
  logic [InstAddrBus-1:0] fetch_pc, fetch_pc_nxt;
  logic [2:0]             iss_cnt, iss_cnt_nxt;
  logic [2:0]             rcv_cnt, rcv_cnt_nxt;
  logic                   pend, pend_nxt;
  logic [InstBus-1:0]     inst_nxt;
  logic [InstAddrBus-1:0] inst_pc_nxt;

  assign mem_req    = (rst != RstEnable) && (state == IfFetch) && (iss_cnt < 3'd4)
                      && !stall_in && !br_flag;
  assign mem_addr   = fetch_pc + {29'd0, iss_cnt};
  assign inst_valid = (state == IfHold);
  assign pc_back    = fetch_pc;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    iss_cnt_nxt  = iss_cnt;
    rcv_cnt_nxt  = rcv_cnt;
    pend_nxt     = 1'b0;
    inst_nxt     = inst;
    inst_pc_nxt  = inst_pc;
    if (br_flag) begin
      // Redirect wins over everything, including a handshake in this cycle.
      fetch_pc_nxt = {br_target[31:2], 2'b00};
      iss_cnt_nxt  = 3'd0;
      rcv_cnt_nxt  = 3'd0;
      state_nxt    = IfFetch;
    end else begin
      if (mem_req && mem_gnt) begin
        iss_cnt_nxt = iss_cnt + 3'd1;
        pend_nxt    = 1'b1;
      end
      if (pend) begin
        inst_nxt[{rcv_cnt[1:0], 3'b000} +: 8] = mem_rdata;
        rcv_cnt_nxt = rcv_cnt + 3'd1;
        if (rcv_cnt == 3'd3) begin
          state_nxt   = IfHold;
          inst_pc_nxt = fetch_pc;
        end
      end
      if ((state == IfHold) && inst_ready) begin
        fetch_pc_nxt = fetch_pc + 32'd4;
        iss_cnt_nxt  = 3'd0;
        rcv_cnt_nxt  = 3'd0;
        state_nxt    = IfFetch;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state    <= IfFetch;
      fetch_pc <= '0;
      iss_cnt  <= 3'd0;
      rcv_cnt  <= 3'd0;
      pend     <= 1'b0;
      inst     <= '0;
      inst_pc  <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      iss_cnt  <= iss_cnt_nxt;
      rcv_cnt  <= rcv_cnt_nxt;
      pend     <= pend_nxt;
      inst     <= inst_nxt;
      inst_pc  <= inst_pc_nxt;
    end
  end

endmodule
